// File: rtl/reg_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_write_arbiter: round-robin N-way writer for one shared register |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module reg_write_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
  output logic [W-1:0]         Q,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 valid,
  output logic [7:0]           wr_cnt
);

  localparam int OW = $clog2(N);
  localparam logic [OW:0] C_NUM_REQ = (OW+1)'(N);

  logic [W-1:0]  data_q,  data_d;
  logic [N-1:0]  gnt_q,   gnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          valid_q, valid_d;
  logic [7:0]    cnt_q,   cnt_d;

  logic [W-1:0]  w_wd [N];
  logic [N-1:0]  w_elig;
  logic          w_found;
  logic [OW-1:0] w_win;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_wd[gi] = wdata[gi*W +: W];
  end

  // Scan offsets from farthest to nearest so the nearest eligible index
  // after the current owner is the one left standing.
  always_comb begin
    logic [OW:0] v_sum;
    w_elig  = req & ~gnt_q;
    w_found = 1'b0;
    w_win   = owner_q;
    v_sum   = '0;
    for (int k = N; k >= 1; k--) begin
      v_sum = {1'b0, owner_q} + (OW+1)'(k);
      if (v_sum >= C_NUM_REQ) begin
        v_sum = v_sum - C_NUM_REQ;
      end
      if (w_elig[v_sum[OW-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_sum[OW-1:0];
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    gnt_d   = '0;
    owner_d = owner_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (w_found) begin
      data_d  = w_wd[w_win];
      gnt_d   = N'(1) << w_win;
      owner_d = w_win;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      gnt_q   <= '0;
      owner_q <= OW'(N-1);
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Q      = data_q;
  assign gnt    = gnt_q;
  assign owner  = owner_q;
  assign valid  = valid_q;
  assign wr_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reg_write_arbiter: directed + randomized bench with ref model    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_reg_write_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [W-1:0] Q;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         valid;
  logic [7:0]   wr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  reg_write_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .Q(Q), .gnt(gnt), .owner(owner), .valid(valid), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  // Reference: register value, last winner index (-1 when idle edge), count
  int m_q     = 0;
  int m_owner = N-1;
  int m_last  = -1;
  int m_cnt   = 0;
  bit m_valid = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= 0; m_owner <= N-1; m_last <= -1; m_cnt <= 0; m_valid <= 1'b0;
    end else begin
      int win;
      win = -1;
      for (int off = 1; off <= N; off++) begin
        int idx;
        idx = (m_owner + off) % N;
        if (win < 0 && req[idx] && idx != m_last) win = idx;
      end
      if (win >= 0) begin
        m_q     <= int'(wdata[win*W +: W]);
        m_owner <= win;
        m_last  <= win;
        m_valid <= 1'b1;
        m_cnt   <= (m_cnt + 1) % 256;
      end else begin
        m_last  <= -1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] eg;
    eg = '0;
    if (m_last >= 0) eg[m_last] = 1'b1;
    chk("model_Q",      32'(Q),      m_q);
    chk("model_gnt",    32'(gnt),    32'(eg));
    chk("model_owner",  32'(owner),  m_owner);
    chk("model_valid",  32'(valid),  32'(m_valid));
    chk("model_wr_cnt", 32'(wr_cnt), m_cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string nm, input int eq, input int eg, input int eo,
                            input int ev, input int ec);
    chk({nm, "_Q"},      32'(Q),      eq);
    chk({nm, "_gnt"},    32'(gnt),    eg);
    chk({nm, "_owner"},  32'(owner),  eo);
    chk({nm, "_valid"},  32'(valid),  ev);
    chk({nm, "_wr_cnt"}, 32'(wr_cnt), ec);
  endtask

  initial begin
    int exp_g [5];
    int exp_q [5];
    int saved_cnt;
    exp_g = '{1, 2, 4, 8, 1};
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

    #12;
    expect_all("reset", 0, 0, 3, 0, 0);
    rst = 1'b0;

    // Single persistent requester: granted every other edge
    req = 4'b0001;
    wdata[7:0] = 8'hA5;
    step(); expect_all("single1", 8'hA5, 4'b0001, 0, 1, 1);
    step(); chk("single2_gnt", 32'(gnt), 0);
    step(); chk("single3_gnt", 32'(gnt), 1); chk("single3_cnt", 32'(wr_cnt), 2);

    // Asynchronous reset between edges during full contention
    req   = 4'b1111;
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    step();
    #2 rst = 1'b1;
    #1 expect_all("midrst", 0, 0, 3, 0, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("contend_gnt", 32'(gnt), exp_g[i]);
      chk("contend_Q",   32'(Q),   exp_q[i]);
    end

    // Skip and wrap
    step(); chk("skip_pre1_gnt", 32'(gnt), 4'b0010);
    step(); chk("skip_pre2_gnt", 32'(gnt), 4'b0100);
    req = 4'b1001;
    step(); chk("skip_gnt", 32'(gnt), 4'b1000); chk("skip_owner", 32'(owner), 3);
    step(); chk("wrap_gnt", 32'(gnt), 4'b0001); chk("wrap_owner", 32'(owner), 0);

    // Idle hold
    req = 4'b0010;
    wdata[15:8] = 8'h3C;
    step(); chk("idle_wr_gnt", 32'(gnt), 4'b0010); chk("idle_wr_Q", 32'(Q), 8'h3C);
    saved_cnt = m_cnt;
    req = 4'b0000;
    repeat (5) begin
      step();
      chk("idle_Q", 32'(Q), 8'h3C);
      chk("idle_owner", 32'(owner), 1);
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_cnt", 32'(wr_cnt), saved_cnt);
    end

    // Counter wrap over 256 grants
    rst = 1'b1;
    #1 rst = 1'b0;
    req = 4'b0011;
    repeat (256) begin
      step();
      chk("wrap_valid", 32'(valid), 1);
    end
    chk("cnt_wrap0", 32'(wr_cnt), 0);
    step();
    chk("cnt_wrap1", 32'(wr_cnt), 1);

    // Randomized traffic obeying the hold-until-granted handshake
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && gnt[i]) begin
          if ($urandom_range(1, 0) == 1) wdata[i*W +: W] = 8'($urandom);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(2, 0) == 0) begin
          req[i] = 1'b1;
          wdata[i*W +: W] = 8'($urandom);
        end
      end
      if (c == 1500) begin
        rst = 1'b1;
        #1 rst = 1'b0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter for one shared W-bit D-flip-flop register. N requesters each present a write request and data; the block picks one winner per clock edge, loads the winner's data into the register, and returns a one-cycle grant pulse. It sits between several producers and a single storage register, which it owns internally. It also tracks the last writer, a written-since-reset flag and a wrapping write count.

## Interface
- N, 4, number of requesters (2..16)
- W, 8, data width of the shared register
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- req  input  N  per-requester write request, level; bit i = requester i
- wdata  input  N*W  packed write data; requester i at bits [i*W +: W]
- Q  output  W  shared register contents
- gnt  output  N  registered one-hot grant pulse; all zero when idle
- owner  output  clog2(N)  index of the most recent winner
- valid  output  1  high once the register has been written since reset
- wr_cnt  output  8  count of completed writes, wraps modulo 256

## Operation
- Reset values, applied asynchronously on rst high: Q=0, gnt=0, owner=N-1, valid=0, wr_cnt=0. owner=N-1 makes requester 0 highest priority after reset.
- Eligibility at an edge: req[i]=1 and gnt[i]=0. A requester granted in the current cycle is masked for that edge.
- Priority is round-robin, starting at (owner+1) mod N and ascending with wrap. The first eligible index wins.
- On an edge with at least one eligible requester:
  - Q <= wdata of the winner
  - gnt <= one-hot of the winner
  - owner <= winner
  - valid <= 1
  - wr_cnt <= wr_cnt+1 mod 256
- On an edge with no eligible requester: gnt <= 0; Q, owner, valid and wr_cnt hold.
- Handshake:
  - A requester holds req and wdata stable until it sees its gnt bit high.
  - Its write is complete in the cycle gnt is high.
  - It may keep req high to request another write; that request is eligible from the following edge onward.
- A single persistent requester is therefore granted every other cycle. With other requesters present, no requester waits more than N-1 grants.
- wdata of non-winners is ignored. There is no combinational path from req or wdata to any output.

## Timing
- Latency: a request eligible at edge k produces gnt, Q and owner updated immediately after edge k, valid for the cycle [k, k+1).
- Throughput: one write per cycle when at least two requesters alternate.
- Simultaneous requests at one edge: exactly one grant. Losers stay pending with no lost state.
- Round-robin wrap: owner=N-1 → search starts at 0.
- wr_cnt wraps from 255 to 0 with no flag.
- Reset mid-operation: outputs go to their reset values asynchronously, without waiting for clk. A pending request is dropped and must be re-evaluated from the first edge after rst falls. If rst is deasserted while req is held high, the first grant occurs at the next edge, not at the deassertion.

## Test plan
- Reset mid-run: with req=1111 active, assert rst between edges. Required: Q=0x00, gnt=0000, owner=3, valid=0, wr_cnt=0 immediately. After release with req=1111, the first grant is gnt=0001.
- Single requester: req=0001, wdata0=0xA5. Required:
  - after edge 1: Q=0xA5, gnt=0001, owner=0, valid=1, wr_cnt=1
  - after edge 2: gnt=0000 (masked)
  - after edge 3: gnt=0001, wr_cnt=2
- Full contention: req=1111 held, wdata_i=0x10+i. Required: after successive edges gnt = 0001, 0010, 0100, 1000, 0001, and Q = 0x10, 0x11, 0x12, 0x13, 0x10.
- Skip and wrap: after a grant to requester 2, set req=1001. Required: next gnt=1000, then gnt=0001, and owner=3, then owner=0.
- Idle hold: after a write of 0x3C by requester 1, set req=0000 for 5 edges. Required: Q stays 0x3C, owner=1, gnt=0000, wr_cnt unchanged.
- Counter wrap: perform 256 grants with req=0011. Required: wr_cnt reads 0 after the 256th grant and 1 after the 257th; valid stays 1 throughout.
